buffer_wr_arbiter: RTL and testbench
====================================

// Module: buffer_wr_arbiter
// PURPOSE
//  Owns the write port of the dual-port frame buffer (addr_in/data_in/regwrite side).
//  Shares it between the camera capture stream and the CPU/drawing port.
//  Camera has priority; a starvation guard guarantees the CPU a slot.
//  A built-in clear engine fills every location with one colour on request.
//  Read port (clk_r side, VGA scan) is untouched; this block is single-clock on the write clock.
// PARAMETERS
//  AW     13  address bits; NPOS = 2**AW locations (must match frame buffer)
//  DW     15  data bits (must match frame buffer)
//  STARVE 8   max consecutive camera grants while cpu_valid is pending (>=1)
// PORTS
//  clk        in   1   write clock (same clock as frame buffer clk_w)
//  rst_n      in   1   asynchronous, active-low reset
//  cam_valid  in   1   camera write request
//  cam_addr   in   AW  camera write address
//  cam_data   in   DW  camera pixel
//  cam_ready  out  1   camera transfer accepted when cam_valid&&cam_ready
//  cpu_valid  in   1   CPU/drawing write request
//  cpu_addr   in   AW  CPU write address
//  cpu_data   in   DW  CPU pixel
//  cpu_ready  out  1   CPU transfer accepted when cpu_valid&&cpu_ready
//  clr_start  in   1   1-cycle pulse: start full-buffer clear
//  clr_color  in   DW  fill value, sampled with clr_start
//  clr_busy   out  1   clear in progress
//  clr_done   out  1   1-cycle pulse on the last clear write
//  mem_addr   out  AW  -> frame buffer addr_in (registered)
//  mem_data   out  DW  -> frame buffer data_in (registered)
//  mem_we     out  1   -> frame buffer regwrite (registered)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=RUN, mem_we=0, mem_addr=0, mem_data=0, clr_busy=0,
//    clr_done=0, streak=0, clear counter=0. Reset mid-clear aborts it; no clr_done.
//  - FSM: RUN, CLEAR. RUN->CLEAR on clr_start (cycle after). CLEAR->RUN after write NPOS-1.
//    clr_start while in CLEAR is ignored (colour not re-sampled).
//  - Readies are combinational, never depend on own valid:
//    cam_ready = RUN && !(cpu_valid && streak==STARVE)
//    cpu_ready = RUN && (!cam_valid || streak==STARVE)
//    At most one transfer per cycle; both readies 0 in CLEAR.
//  - Streak: +1 on camera grant while cpu_valid=1; cleared on CPU grant or when cpu_valid=0;
//    saturates at STARVE.
//  - Latency: transfer accepted in cycle N -> mem_addr/mem_data/mem_we=1 in cycle N+1 for
//    exactly one cycle. No transfer -> mem_we=0, mem_addr/mem_data hold.
//  - clr_start in RUN at cycle N: transfers in cycle N still accepted (written N+1);
//    clr_busy=1 from N+1 until state returns RUN; clear writes addr k=0..NPOS-1 with
//    clr_color appear at N+2+k, mem_we=1 every one of those NPOS cycles back-to-back.
//  - clr_done=1 in the cycle mem_addr=NPOS-1 of the clear is on the outputs; readies
//    re-enable the cycle after the last clear counter value is issued.
//  - Counter is AW bits; terminal detect at all-ones, no wrap into a second pass.
//  - No data reordering, no buffering: a non-ready requester must hold valid/addr/data.
// STRUCTURE
//  - Package buffer_pkg: default AW/DW localparams, state enum {RUN, CLEAR}.
//  - Sub-module clear_engine: colour latch + AW-bit address counter + done pulse.
//  - Top: arbitration/streak logic, output register, FSM.
// TESTING (bench with AW=4, DW=15, STARVE=2)
//  1 Reset: drive requests during rst_n=0 -> readies 0, mem_we=0; release -> cam_ready=1.
//  2 Single CPU write addr 5 data 0x1234 -> cpu_ready=1, next cycle mem_addr=5,
//    mem_data=0x1234, mem_we=1, then mem_we=0.
//  3 cam_valid and cpu_valid held high -> grants cam,cam,cpu,cam,cam,cpu...; mem writes
//    in same order one cycle later, no cycle without mem_we.
//  4 clr_start, clr_color=0x7C00 -> 16 back-to-back writes addr 0..15 of 0x7C00,
//    clr_done high only with addr 15, readies 0 throughout, requests resume after.
//  5 clr_start with pending cam write addr 3 -> cam write at N+1, clear addr 0 at N+2;
//    second clr_start mid-clear ignored (still exactly 16 writes, one clr_done).
//  6 rst_n low at clear addr 7 -> mem_we=0 immediately, clr_busy=0, no clr_done.

Source files
------------

// File: rtl/buffer_wr_arbiter_pkg.sv
// Shared defaults and types for the frame-buffer write-port arbiter.
package buffer_pkg;

  localparam int DEF_AW     = 13;
  localparam int DEF_DW     = 15;
  localparam int DEF_STARVE = 8;

  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } wr_state_e;

  // Width needed to count camera grants up to and including the starvation limit.
  function automatic int streak_bits(input int starve);
    return $clog2(starve + 1);
  endfunction

endpackage

// File: rtl/buffer_wr_arbiter_clear_engine.sv
// Clear engine: latches the fill colour, walks every address once and pulses done
// alongside the final write.
module clear_engine
  import buffer_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] start_color,
  input  logic          active,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] color,
  output logic          last,
  output logic          done
);

  logic [AW-1:0] cnt_reg;
  logic [DW-1:0] color_reg;
  logic          done_reg;

  assign addr  = cnt_reg;
  assign color = color_reg;
  assign last  = active && (&cnt_reg);
  assign done  = done_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg   <= '0;
      color_reg <= '0;
      done_reg  <= 1'b0;
    end else begin
      // done is registered so it lines up with the last write on the memory port
      done_reg <= active && (&cnt_reg);
      if (start) begin
        cnt_reg   <= '0;
        color_reg <= start_color;
      end else if (active) begin
        cnt_reg <= cnt_reg + AW'(1);
      end
    end
  end

endmodule

// File: rtl/buffer_wr_arbiter.sv
// Write-port arbiter for the frame buffer: camera-priority with a CPU starvation
// guard, plus a full-buffer clear mode. Single clock (frame buffer write clock).
module buffer_wr_arbiter
  import buffer_pkg::*;
#(
  parameter int AW     = DEF_AW,
  parameter int DW     = DEF_DW,
  parameter int STARVE = DEF_STARVE
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cam_valid,
  input  logic [AW-1:0] cam_addr,
  input  logic [DW-1:0] cam_data,
  output logic          cam_ready,
  input  logic          cpu_valid,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_data,
  output logic          cpu_ready,
  input  logic          clr_start,
  input  logic [DW-1:0] clr_color,
  output logic          clr_busy,
  output logic          clr_done,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic          mem_we
);

  localparam int             SW       = streak_bits(STARVE);
  localparam logic [SW-1:0]  STARVE_V = SW'(STARVE);

  wr_state_e     state_reg;
  logic [SW-1:0] streak_reg;
  logic [AW-1:0] mem_addr_reg;
  logic [DW-1:0] mem_data_reg;
  logic          mem_we_reg;

  logic          run_ok;
  logic          starved;
  logic          cam_fire;
  logic          cpu_fire;
  logic          clr_kick;
  logic          clr_active;
  logic          clr_last;
  logic [AW-1:0] clr_addr;
  logic [DW-1:0] clr_fill;

  // Readies are held low while reset is asserted so nothing is accepted then.
  assign run_ok    = rst_n && (state_reg == RUN);
  assign starved   = (streak_reg == STARVE_V);
  assign cam_ready = run_ok && !(cpu_valid && starved);
  assign cpu_ready = run_ok && (!cam_valid || starved);
  assign cam_fire  = cam_valid && cam_ready;
  assign cpu_fire  = cpu_valid && cpu_ready;

  assign clr_kick   = (state_reg == RUN) && clr_start;
  assign clr_active = (state_reg == CLEAR);
  assign clr_busy   = clr_active;

  assign mem_addr = mem_addr_reg;
  assign mem_data = mem_data_reg;
  assign mem_we   = mem_we_reg;

  clear_engine #(
    .AW(AW),
    .DW(DW)
  ) u_clear (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (clr_kick),
    .start_color(clr_color),
    .active     (clr_active),
    .addr       (clr_addr),
    .color      (clr_fill),
    .last       (clr_last),
    .done       (clr_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= RUN;
      streak_reg   <= '0;
      mem_addr_reg <= '0;
      mem_data_reg <= '0;
      mem_we_reg   <= 1'b0;
    end else begin
      case (state_reg)
        RUN:     if (clr_start) state_reg <= CLEAR;
        CLEAR:   if (clr_last)  state_reg <= RUN;
        default: state_reg <= RUN;
      endcase

      if (state_reg == CLEAR) begin
        mem_we_reg   <= 1'b1;
        mem_addr_reg <= clr_addr;
        mem_data_reg <= clr_fill;
      end else if (cam_fire) begin
        mem_we_reg   <= 1'b1;
        mem_addr_reg <= cam_addr;
        mem_data_reg <= cam_data;
      end else if (cpu_fire) begin
        mem_we_reg   <= 1'b1;
        mem_addr_reg <= cpu_addr;
        mem_data_reg <= cpu_data;
      end else begin
        mem_we_reg <= 1'b0;
      end

      // Streak only counts camera wins that actually made the CPU wait.
      if (!cpu_valid || cpu_fire) begin
        streak_reg <= '0;
      end else if (cam_fire && !starved) begin
        streak_reg <= streak_reg + SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_buffer_wr_arbiter.sv
// Bench for buffer_wr_arbiter: transaction-level model checked every cycle plus
// directed scenarios with literal expectations.
module tb_buffer_wr_arbiter;

  localparam int AW     = 4;
  localparam int DW     = 15;
  localparam int STARVE = 2;
  localparam int NPOS   = 16;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          cam_valid = 1'b0;
  logic [AW-1:0] cam_addr  = '0;
  logic [DW-1:0] cam_data  = '0;
  logic          cpu_valid = 1'b0;
  logic [AW-1:0] cpu_addr  = '0;
  logic [DW-1:0] cpu_data  = '0;
  logic          clr_start = 1'b0;
  logic [DW-1:0] clr_color = '0;
  logic          cam_ready;
  logic          cpu_ready;
  logic          clr_busy;
  logic          clr_done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_we;

  always #5 clk = ~clk;

  buffer_wr_arbiter #(
    .AW(AW),
    .DW(DW),
    .STARVE(STARVE)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cam_valid(cam_valid),
    .cam_addr (cam_addr),
    .cam_data (cam_data),
    .cam_ready(cam_ready),
    .cpu_valid(cpu_valid),
    .cpu_addr (cpu_addr),
    .cpu_data (cpu_data),
    .cpu_ready(cpu_ready),
    .clr_start(clr_start),
    .clr_color(clr_color),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_we   (mem_we)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: clear pending as "next clear address to emit" (-1 = none), CPU wait
  // count, and the write that must appear on the memory port next.
  int            m_streak   = 0;
  int            m_clr_next = -1;
  logic [DW-1:0] m_color    = '0;
  logic          e_we       = 1'b0;
  logic [AW-1:0] e_addr     = '0;
  logic [DW-1:0] e_data     = '0;
  logic          e_done     = 1'b0;
  string         grants     = "";
  int            done_seen  = 0;

  function automatic logic m_cam_ready();
    return rst_n && (m_clr_next < 0) && !(cpu_valid && (m_streak == STARVE));
  endfunction

  function automatic logic m_cpu_ready();
    return rst_n && (m_clr_next < 0) && (!cam_valid || (m_streak == STARVE));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_streak   = 0;
      m_clr_next = -1;
      e_we       = 1'b0;
      e_addr     = '0;
      e_data     = '0;
      e_done     = 1'b0;
    end else begin
      logic cam_g;
      logic cpu_g;
      cam_g  = cam_valid && m_cam_ready();
      cpu_g  = cpu_valid && m_cpu_ready() && !cam_g;
      e_done = 1'b0;
      if (m_clr_next >= 0) begin
        e_we   = 1'b1;
        e_addr = m_clr_next[AW-1:0];
        e_data = m_color;
        e_done = (m_clr_next == NPOS - 1);
        m_clr_next = (m_clr_next == NPOS - 1) ? -1 : m_clr_next + 1;
      end else begin
        if (cam_g) begin
          e_we = 1'b1; e_addr = cam_addr; e_data = cam_data;
          grants = {grants, "A"};
        end else if (cpu_g) begin
          e_we = 1'b1; e_addr = cpu_addr; e_data = cpu_data;
          grants = {grants, "P"};
        end else begin
          e_we = 1'b0;
        end
        if (clr_start) begin
          m_clr_next = 0;
          m_color    = clr_color;
        end
      end
      if (!cpu_valid || cpu_g) m_streak = 0;
      else if (cam_g && m_streak < STARVE) m_streak = m_streak + 1;
    end
  end

  always @(negedge clk) begin
    chk("cam_ready", 32'(cam_ready), 32'(m_cam_ready()));
    chk("cpu_ready", 32'(cpu_ready), 32'(m_cpu_ready()));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    chk("mem_data", 32'(mem_data), 32'(e_data));
    chk("clr_busy", 32'(clr_busy), 32'(m_clr_next >= 0));
    chk("clr_done", 32'(clr_done), 32'(e_done));
    if (clr_done) done_seen++;
    $display("[TB] t=%0t we=%0b addr=%0d data=0x%0h busy=%0b done=%0b rdy=%0b%0b",
             $time, mem_we, mem_addr, mem_data, clr_busy, clr_done, cam_ready, cpu_ready);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp3 [6];
    int wr_cnt;
    int dn_cnt;
    int done_snap;
    logic hit;
    exp3 = '{1, 1, 2, 1, 1, 2};

    // 1: requests asserted under reset are refused
    cam_valid = 1'b1; cam_addr = 4'hA; cam_data = 15'h0AA;
    cpu_valid = 1'b1; cpu_addr = 4'h2; cpu_data = 15'h222;
    step(); step();
    chk("t1_cam_ready_rst", 32'(cam_ready), 32'd0);
    chk("t1_cpu_ready_rst", 32'(cpu_ready), 32'd0);
    chk("t1_we_rst", 32'(mem_we), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("t1_cam_ready_rel", 32'(cam_ready), 32'd1);
    step();
    cam_valid = 1'b0; cpu_valid = 1'b0;
    chk("t1_first_addr", 32'(mem_addr), 32'hA);
    chk("t1_first_we", 32'(mem_we), 32'd1);
    step();

    // 2: single CPU write
    cpu_valid = 1'b1; cpu_addr = 4'd5; cpu_data = 15'h1234;
    #1;
    chk("t2_cpu_ready", 32'(cpu_ready), 32'd1);
    step();
    cpu_valid = 1'b0;
    chk("t2_addr", 32'(mem_addr), 32'd5);
    chk("t2_data", 32'(mem_data), 32'h1234);
    chk("t2_we", 32'(mem_we), 32'd1);
    step();
    chk("t2_we_off", 32'(mem_we), 32'd0);

    // 3: both requesting -> cam, cam, cpu repeating
    grants = "";
    cam_valid = 1'b1; cam_addr = 4'd1; cam_data = 15'h111;
    cpu_valid = 1'b1; cpu_addr = 4'd2; cpu_data = 15'h222;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t3_we", 32'(mem_we), 32'd1);
      chk("t3_addr", 32'(mem_addr), 32'(exp3[i]));
    end
    cam_valid = 1'b0; cpu_valid = 1'b0;
    n_tests++;
    if (grants != "AAPAAP") begin
      n_fail++;
      $display("FAIL t3_grant_order: got %s, expected AAPAAP", grants);
    end
    step();
    chk("t3_we_off", 32'(mem_we), 32'd0);

    // 4: full clear, CPU waits then resumes
    clr_start = 1'b1; clr_color = 15'h7C00;
    for (int c = 1; c <= 18; c++) begin
      step();
      if (c == 1) begin
        clr_start = 1'b0;
        cpu_valid = 1'b1; cpu_addr = 4'd9; cpu_data = 15'h099;
      end
      if (c >= 2 && c <= 17) begin
        chk("t4_clr_addr", 32'(mem_addr), 32'(c - 2));
        chk("t4_clr_data", 32'(mem_data), 32'h7C00);
        chk("t4_clr_we", 32'(mem_we), 32'd1);
        chk("t4_clr_done", 32'(clr_done), 32'(c == 17));
      end
      if (c <= 17) begin
        chk("t4_cpu_ready", 32'(cpu_ready), 32'(c == 17));
        chk("t4_busy", 32'(clr_busy), 32'(c <= 16));
      end
      if (c == 18) begin
        chk("t4_resume_addr", 32'(mem_addr), 32'd9);
        chk("t4_resume_data", 32'(mem_data), 32'h099);
        chk("t4_resume_we", 32'(mem_we), 32'd1);
        cpu_valid = 1'b0;
      end
    end
    step();

    // 5: clear with a camera write in the same cycle; second start ignored
    cam_valid = 1'b1; cam_addr = 4'd3; cam_data = 15'h333;
    clr_start = 1'b1; clr_color = 15'h0155;
    wr_cnt = 0; dn_cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (c == 1) begin
        chk("t5_cam_addr", 32'(mem_addr), 32'd3);
        chk("t5_cam_data", 32'(mem_data), 32'h333);
        chk("t5_cam_we", 32'(mem_we), 32'd1);
        clr_start = 1'b0; cam_valid = 1'b0;
      end
      if (c == 2) begin
        chk("t5_clr0_addr", 32'(mem_addr), 32'd0);
        chk("t5_clr0_data", 32'(mem_data), 32'h0155);
      end
      if (c == 6) begin clr_start = 1'b1; clr_color = 15'h7FFF; end
      if (c == 7) clr_start = 1'b0;
      if (c >= 2 && mem_we && mem_data == 15'h0155) wr_cnt++;
      if (clr_done) dn_cnt++;
    end
    chk("t5_clear_writes", 32'(wr_cnt), 32'd16);
    chk("t5_done_pulses", 32'(dn_cnt), 32'd1);
    chk("t5_idle_after", 32'(clr_busy), 32'd0);

    // 6: reset mid-clear aborts it
    clr_start = 1'b1; clr_color = 15'h2AAA;
    hit = 1'b0;
    for (int c = 1; c <= 30 && !hit; c++) begin
      step();
      if (c == 1) clr_start = 1'b0;
      if (mem_we && clr_busy && mem_addr == 4'd7) hit = 1'b1;
    end
    chk("t6_reached_addr7", 32'(hit), 32'd1);
    done_snap = done_seen;
    rst_n = 1'b0;
    #1;
    chk("t6_we_rst", 32'(mem_we), 32'd0);
    chk("t6_busy_rst", 32'(clr_busy), 32'd0);
    chk("t6_addr_rst", 32'(mem_addr), 32'd0);
    step(); step();
    rst_n = 1'b1;
    repeat (20) step();
    chk("t6_no_done", 32'(done_seen - done_snap), 32'd0);
    chk("t6_busy_after", 32'(clr_busy), 32'd0);
    chk("t6_we_after", 32'(mem_we), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
